// File: rtl/ether_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ether_tx_arbiter
// Purpose  : Round-robin arbiter sharing one ethernet_tx between NUM_REQ frame
//            sources. Latches the winner's dest MAC / ethertype, forwards its
//            N-bit payload stream, zero-pads short payloads to the Ethernet
//            minimum, waits for ethernet_tx to finish the frame and then holds
//            off for the inter-frame gap before the next grant.
// Ports    : clk, rst (async, active-low)
//            req / req_dest_mac / req_etype / req_axiid / req_axiiv / req_last
//                 - per-requester request and payload stream (slice i = req i)
//            grant                  - one-hot, held through the payload stream
//            tx_axiiv / tx_axiid    - payload stream to ethernet_tx
//            tx_dest_mac / tx_etype - frame header fields, stable per frame
//            tx_axiov_mon           - ethernet_tx axiov, frame completion
//            busy                   - high whenever not idle
//            underrun               - sticky, granted stream broke before last
//            frame_cnt              - per-requester completed-frame counters
//                                     (only with ETHER_TX_ARB_STATS_EN)
// Options  : `define ETHER_TX_ARB_STATS_EN to add the frame_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module ether_tx_arbiter #(
    parameter int N                 = 2,
    parameter int NUM_REQ           = 2,
    parameter int MIN_PAYLOAD_BYTES = 46,
    parameter int IFG_CYCLES        = 96 / N
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [48*NUM_REQ-1:0]   req_dest_mac,
    input  logic [16*NUM_REQ-1:0]   req_etype,
    input  logic [N*NUM_REQ-1:0]    req_axiid,
    input  logic [NUM_REQ-1:0]      req_axiiv,
    input  logic [NUM_REQ-1:0]      req_last,
    output logic [NUM_REQ-1:0]      grant,
    output logic                    tx_axiiv,
    output logic [N-1:0]            tx_axiid,
    output logic [47:0]             tx_dest_mac,
    output logic [15:0]             tx_etype,
    input  logic                    tx_axiov_mon,
    output logic                    busy,
    output logic                    underrun
`ifdef ETHER_TX_ARB_STATS_EN
    ,
    output logic [16*NUM_REQ-1:0]   frame_cnt
`endif
);

    localparam int C_MIN_SYMS = MIN_PAYLOAD_BYTES * 8 / N;
    localparam int C_CW       = $clog2(C_MIN_SYMS + 1);
    localparam int C_GW       = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;
    localparam int C_IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [C_CW-1:0]    C_MIN_CNT = C_CW'(C_MIN_SYMS);
    localparam logic [C_GW-1:0]    C_IFG     = C_GW'(IFG_CYCLES);
    localparam logic [NUM_REQ-1:0] C_ONE     = NUM_REQ'(1);

    localparam logic [2:0] C_ST_IDLE  = 3'd0;
    localparam logic [2:0] C_ST_GRANT = 3'd1;
    localparam logic [2:0] C_ST_STRM  = 3'd2;
    localparam logic [2:0] C_ST_PAD   = 3'd3;
    localparam logic [2:0] C_ST_WAIT  = 3'd4;
    localparam logic [2:0] C_ST_GAP   = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [C_IW-1:0]    cur_q, cur_d;
    logic [C_IW-1:0]    rr_q, rr_d;
    logic [C_CW-1:0]    sym_q, sym_d;
    logic [C_GW-1:0]    gap_q, gap_d;
    logic               txv_q, txv_d;
    logic [N-1:0]       txd_q, txd_d;
    logic [47:0]        mac_q, mac_d;
    logic [15:0]        ety_q, ety_d;
    logic               busy_q, busy_d;
    logic               undr_q, undr_d;
    logic               seen_q, seen_d;
`ifdef ETHER_TX_ARB_STATS_EN
    logic [16*NUM_REQ-1:0] cnt_q, cnt_d;
`endif

    logic               pick_vld;
    logic [C_IW-1:0]    pick_idx;
    logic               cur_v;
    logic               cur_last;
    logic [N-1:0]       cur_d_sym;
    logic [C_CW-1:0]    sym_inc;

    // (base + off) modulo NUM_REQ; both operands are already below NUM_REQ.
    function automatic logic [C_IW-1:0] wrap_add(input logic [C_IW-1:0] base, input int off);
        int j;
        j = int'(base) + off;
        if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
        end
        return C_IW'(j);
    endfunction

    // First requester at or after the round-robin pointer.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_vld && req[wrap_add(rr_q, k)]) begin
                pick_vld = 1'b1;
                pick_idx = wrap_add(rr_q, k);
            end
        end
    end

    assign cur_v     = req_axiiv[cur_q];
    assign cur_last  = req_last[cur_q];
    assign cur_d_sym = req_axiid[cur_q*N +: N];
    // Symbol count saturates at the minimum; only "reached minimum" matters.
    assign sym_inc   = (sym_q == C_MIN_CNT) ? sym_q : sym_q + C_CW'(1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cur_d   = cur_q;
        rr_d    = rr_q;
        sym_d   = sym_q;
        gap_d   = gap_q;
        txv_d   = 1'b0;
        txd_d   = '0;
        mac_d   = mac_q;
        ety_d   = ety_q;
        undr_d  = undr_q;
        // Remembers that ethernet_tx raised axiov for this frame; it usually
        // rises while payload is still streaming, before WAIT_DONE.
        seen_d  = (state_q == C_ST_IDLE) ? 1'b0 : (seen_q | tx_axiov_mon);
`ifdef ETHER_TX_ARB_STATS_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            C_ST_IDLE: begin
                sym_d = '0;
                if (pick_vld) begin
                    cur_d   = pick_idx;
                    grant_d = C_ONE << pick_idx;
                    mac_d   = req_dest_mac[pick_idx*48 +: 48];
                    ety_d   = req_etype[pick_idx*16 +: 16];
                    state_d = C_ST_GRANT;
                end
            end
            C_ST_GRANT, C_ST_STRM: begin
                if (cur_v) begin
                    txv_d = 1'b1;
                    txd_d = cur_d_sym;
                    sym_d = sym_inc;
                    if (state_q == C_ST_GRANT) begin
                        rr_d    = wrap_add(cur_q, 1);
                        state_d = C_ST_STRM;
                    end
                    if (cur_last) begin
                        grant_d = '0;
                        state_d = (sym_inc < C_MIN_CNT) ? C_ST_PAD : C_ST_WAIT;
                    end
                end else if (state_q == C_ST_STRM) begin
                    // Stream broke before last: close the frame. The first pad
                    // symbol goes out now so the stream has no bubble.
                    undr_d  = 1'b1;
                    grant_d = '0;
                    if (sym_q < C_MIN_CNT) begin
                        txv_d   = 1'b1;
                        sym_d   = sym_inc;
                        state_d = C_ST_PAD;
                    end else begin
                        state_d = C_ST_WAIT;
                    end
                end
            end
            C_ST_PAD: begin
                if (sym_q < C_MIN_CNT) begin
                    txv_d = 1'b1;
                    sym_d = sym_inc;
                end else begin
                    state_d = C_ST_WAIT;
                end
            end
            C_ST_WAIT: begin
                if (seen_q && !tx_axiov_mon) begin
                    gap_d   = C_IFG;
                    state_d = C_ST_GAP;
`ifdef ETHER_TX_ARB_STATS_EN
                    cnt_d[cur_q*16 +: 16] = cnt_q[cur_q*16 +: 16] + 16'd1;
`endif
                end
            end
            C_ST_GAP: begin
                if (gap_q <= C_GW'(1)) begin
                    gap_d   = '0;
                    state_d = C_ST_IDLE;
                end else begin
                    gap_d = gap_q - C_GW'(1);
                end
            end
            default: begin
                state_d = C_ST_IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != C_ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= C_ST_IDLE;
            grant_q <= '0;
            cur_q   <= '0;
            rr_q    <= '0;
            sym_q   <= '0;
            gap_q   <= '0;
            txv_q   <= 1'b0;
            txd_q   <= '0;
            mac_q   <= '0;
            ety_q   <= '0;
            busy_q  <= 1'b0;
            undr_q  <= 1'b0;
            seen_q  <= 1'b0;
`ifdef ETHER_TX_ARB_STATS_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cur_q   <= cur_d;
            rr_q    <= rr_d;
            sym_q   <= sym_d;
            gap_q   <= gap_d;
            txv_q   <= txv_d;
            txd_q   <= txd_d;
            mac_q   <= mac_d;
            ety_q   <= ety_d;
            busy_q  <= busy_d;
            undr_q  <= undr_d;
            seen_q  <= seen_d;
`ifdef ETHER_TX_ARB_STATS_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign tx_axiiv    = txv_q;
    assign tx_axiid    = txd_q;
    assign tx_dest_mac = mac_q;
    assign tx_etype    = ety_q;
    assign busy        = busy_q;
    assign underrun    = undr_q;
`ifdef ETHER_TX_ARB_STATS_EN
    assign frame_cnt   = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ether_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ether_tx_arbiter
// Purpose  : Randomized self-checking bench for ether_tx_arbiter. Requesters
//            raise frames with random headers, lengths and occasional early
//            stream breaks; a frame-level reference model predicts the grant
//            order, the transmitted symbol stream (payload + zero padding),
//            header fields, underrun flag and inter-frame gap timing.
//            A simple ethernet_tx stand-in produces tx_axiov_mon.
// Options  : ETHER_TX_ARB_STATS_EN also checks the frame_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ether_tx_arbiter;

    localparam int N        = 2;
    localparam int NR       = 2;
    localparam int MIN_SYMS = 46 * 8 / N;
    localparam int IFG      = 96 / N;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NR-1:0]        req;
    logic [48*NR-1:0]     req_dest_mac;
    logic [16*NR-1:0]     req_etype;
    logic [N*NR-1:0]      req_axiid;
    logic [NR-1:0]        req_axiiv;
    logic [NR-1:0]        req_last;
    logic [NR-1:0]        grant;
    logic                 tx_axiiv;
    logic [N-1:0]         tx_axiid;
    logic [47:0]          tx_dest_mac;
    logic [15:0]          tx_etype;
    logic                 tx_axiov_mon = 1'b0;
    logic                 busy;
    logic                 underrun;
`ifdef ETHER_TX_ARB_STATS_EN
    logic [16*NR-1:0]     frame_cnt;
`endif

    ether_tx_arbiter #(
        .N                 (N),
        .NUM_REQ           (NR),
        .MIN_PAYLOAD_BYTES (46),
        .IFG_CYCLES        (IFG)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_dest_mac (req_dest_mac),
        .req_etype    (req_etype),
        .req_axiid    (req_axiid),
        .req_axiiv    (req_axiiv),
        .req_last     (req_last),
        .grant        (grant),
        .tx_axiiv     (tx_axiiv),
        .tx_axiid     (tx_axiid),
        .tx_dest_mac  (tx_dest_mac),
        .tx_etype     (tx_etype),
        .tx_axiov_mon (tx_axiov_mon),
        .busy         (busy),
        .underrun     (underrun)
`ifdef ETHER_TX_ARB_STATS_EN
        ,
        .frame_cnt    (frame_cnt)
`endif
    );

    always #10 clk = ~clk;

    // ethernet_tx stand-in: axiov follows the payload stream a few cycles
    // late and stays up a few cycles after it (preamble / CRC latency).
    logic [9:0] mon_sh = '0;
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            mon_sh       = '0;
            tx_axiov_mon = 1'b0;
        end else begin
            mon_sh       = {mon_sh[8:0], tx_axiiv};
            tx_axiov_mon = |mon_sh[9:3];
        end
    end

    // Reference model state
    logic [NR-1:0] pend;
    logic [47:0]   mac_a [NR];
    logic [15:0]   ety_a [NR];
    int            len_a [NR];
    int            brk_a [NR];
    int            fcnt  [NR];
    int            ptr;
    logic          exp_under;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend      = '0;
        ptr       = 0;
        exp_under = 1'b0;
        for (int i = 0; i < NR; i++) fcnt[i] = 0;
    endtask

    task automatic raise(input logic [NR-1:0] mask, input int flen, input int fbrk);
        for (int i = 0; i < NR; i++) begin
            if (mask[i]) begin
                pend[i]  = 1'b1;
                req[i]   = 1'b1;
                mac_a[i] = 48'({$urandom(), $urandom()});
                ety_a[i] = 16'($urandom());
                len_a[i] = (flen > 0) ? flen : int'($urandom_range(1, 260));
                if (fbrk > 0)
                    brk_a[i] = fbrk;
                else if (flen == 0 && $urandom_range(0, 5) == 0)
                    brk_a[i] = int'($urandom_range(1, 200));
                else
                    brk_a[i] = 0;
                req_dest_mac[i*48 +: 48] = mac_a[i];
                req_etype[i*16 +: 16]    = ety_a[i];
            end
        end
    endtask

    // Called at a negedge with the DUT idle (or just returned to idle).
    task automatic do_frame(input logic [NR-1:0] mask, input int flen, input int fbrk);
        int e, sent, nsend, nvalid, errs, cyc, cnt, exp_len;
        logic done, seen;
        logic [N-1:0] d;
        logic [N-1:0] q[$];
        logic [NR-1:0] m;
        if (pend == '0) begin
            m = mask;
            if (m == '0) m = NR'($urandom_range(1, (1 << NR) - 1));
            raise(m, flen, fbrk);
        end
        e = -1;
        for (int k = 0; k < NR; k++)
            if (e < 0 && pend[(ptr + k) % NR]) e = (ptr + k) % NR;
        ptr = (e + 1) % NR;

        @(negedge clk);
        check_eq("grant", 64'(grant), 64'(1) << e);
        check_eq("dest_mac", 64'(tx_dest_mac), 64'(mac_a[e]));
        check_eq("etype", 64'(tx_etype), 64'(ety_a[e]));
        req[e]  = 1'b0;
        pend[e] = 1'b0;
        nsend   = (brk_a[e] > 0) ? brk_a[e] : len_a[e];
        if (brk_a[e] > 0) exp_under = 1'b1;
        exp_len = (nsend > MIN_SYMS) ? nsend : MIN_SYMS;

        sent = 0; nvalid = 0; errs = 0; cyc = 0; done = 1'b0; seen = 1'b0;
        while (!done && cyc < 2000) begin
            for (int i = 0; i < NR; i++) begin
                if (i == e) begin
                    if (sent < nsend) begin
                        d = N'($urandom());
                        q.push_back(d);
                        req_axiiv[i]       = 1'b1;
                        req_axiid[i*N +: N] = d;
                        req_last[i]        = (brk_a[e] == 0 && sent == nsend - 1);
                        sent++;
                    end else begin
                        req_axiiv[i]       = 1'b0;
                        req_last[i]        = 1'b0;
                        req_axiid[i*N +: N] = '0;
                    end
                end else begin
                    req_axiiv[i]        = 1'($urandom());
                    req_last[i]         = 1'($urandom());
                    req_axiid[i*N +: N] = N'($urandom());
                    if (!pend[i]) begin
                        req_dest_mac[i*48 +: 48] = 48'({$urandom(), $urandom()});
                        req_etype[i*16 +: 16]    = 16'($urandom());
                    end
                end
            end
            @(negedge clk);
            cyc++;
            if (tx_axiiv) begin
                d = (nvalid < q.size()) ? q[nvalid] : '0;
                if (tx_axiid !== d) errs++;
                nvalid++;
                seen = 1'b1;
            end else if (seen) begin
                done = 1'b1;
            end
        end
        req_axiiv = '0;
        req_last  = '0;
        req_axiid = '0;
        check_eq("stream_end", 64'(done), 64'(1));
        check_eq("tx_len", 64'(nvalid), 64'(exp_len));
        check_eq("tx_data_errs", 64'(errs), 64'(0));
        check_eq("grant_drop", 64'(grant), 64'(0));
        check_eq("mac_hold", 64'(tx_dest_mac), 64'(mac_a[e]));
        check_eq("underrun", 64'(underrun), 64'(exp_under));

        cnt = 0;
        while (tx_axiov_mon && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("busy_in_gap", 64'(busy), 64'(1));
        // The first clock edge that samples axiov low follows this negedge,
        // hence one extra observed edge before busy drops.
        cnt = 0;
        while (busy && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("ifg", 64'(cnt), 64'(IFG + 1));
        fcnt[e]++;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst          = 1'b0;
        req          = '0;
        req_dest_mac = '0;
        req_etype    = '0;
        req_axiid    = '0;
        req_axiiv    = '0;
        req_last     = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_grant", 64'(grant), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_txv", 64'(tx_axiiv), 64'(0));
        check_eq("rst_under", 64'(underrun), 64'(0));
        rst = 1'b1;
        @(negedge clk);

        // Directed: single long frame, short frame, contention, underrun
        do_frame(2'b01, 200, 0);
        do_frame(2'b10, 8, 0);
        for (int f = 0; f < 4; f++) do_frame(2'b11, 0, 0);
        do_frame(2'b01, 100, 20);
        do_frame(2'b10, 30, 0);
        // Randomized traffic
        for (int f = 0; f < 12; f++) do_frame('0, 0, 0);
        while (pend != '0) do_frame('0, 0, 0);

        // Reset in the middle of a payload stream
        raise(2'b01, 200, 0);
        @(negedge clk);
        check_eq("pre_rst_grant", 64'(grant), 64'(1));
        req[0]  = 1'b0;
        pend[0] = 1'b0;
        for (int s = 0; s < 50; s++) begin
            req_axiiv[0]   = 1'b1;
            req_axiid[N-1:0] = N'($urandom());
            req_last[0]    = 1'b0;
            @(negedge clk);
        end
        #3 rst = 1'b0;
        #1;
        check_eq("arst_grant", 64'(grant), 64'(0));
        check_eq("arst_txv", 64'(tx_axiiv), 64'(0));
        check_eq("arst_txd", 64'(tx_axiid), 64'(0));
        check_eq("arst_mac", 64'(tx_dest_mac), 64'(0));
        check_eq("arst_etype", 64'(tx_etype), 64'(0));
        check_eq("arst_busy", 64'(busy), 64'(0));
        check_eq("arst_under", 64'(underrun), 64'(0));
`ifdef ETHER_TX_ARB_STATS_EN
        check_eq("arst_frame_cnt", 64'(frame_cnt), 64'(0));
`endif
        req_axiiv = '0;
        req_axiid = '0;
        req_last  = '0;
        req       = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        // Pointer is back at 0, so requester 0 wins the simultaneous request.
        do_frame(2'b11, 0, 0);
        do_frame(2'b00, 0, 0);
        do_frame(2'b01, 0, 0);
        do_frame(2'b01, 0, 0);
`ifdef ETHER_TX_ARB_STATS_EN
        for (int i = 0; i < NR; i++)
            check_eq("frame_cnt", 64'(frame_cnt[i*16 +: 16]), 64'(fcnt[i]));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ether_tx_arbiter.md
Name: ether_tx_arbiter

Overview:
- Shares one ethernet_tx instance between NUM_REQ frame sources, e.g. the controller-input sender and the game-state sender.
- Per frame, it:
  - grants one requester in round-robin order;
  - latches that requester's dest MAC and ethertype;
  - forwards the requester's N-bit payload stream to ethernet_tx, zero-padding to the Ethernet minimum payload;
  - waits for ethernet_tx to finish the frame;
  - enforces the inter-frame gap before the next grant.

Parameters:
- N, 2: symbol width in bits (2 or 4); must match ethernet_tx.
- NUM_REQ, 2: number of requesters (2..4).
- MIN_PAYLOAD_BYTES, 46: minimum payload; shorter frames are zero-padded.
- IFG_CYCLES, 96/N: idle cycles after ethernet_tx axiov falls before the next grant.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  per-requester frame request, level, held until granted.
- req_dest_mac  in  48*NUM_REQ  dest MAC, slice i belongs to requester i.
- req_etype  in  16*NUM_REQ  ethertype, slice i.
- req_axiid  in  N*NUM_REQ  payload symbol, slice i.
- req_axiiv  in  NUM_REQ  payload symbol valid.
- req_last  in  NUM_REQ  marks final payload symbol, qualified by req_axiiv.
- grant  out  NUM_REQ  one-hot; high from grant through end of payload stream.
- tx_axiiv  out  1  to ethernet_tx axiiv.
- tx_axiid  out  N  to ethernet_tx axiid.
- tx_dest_mac  out  48  to ethernet_tx dest_mac; stable for the whole frame.
- tx_etype  out  16  to ethernet_tx etype; stable for the whole frame.
- tx_axiov_mon  in  1  ethernet_tx axiov, used for completion detection.
- busy  out  1  high in every state except IDLE.
- underrun  out  1  sticky; set when a granted stream breaks before last; cleared only by reset.

Behaviour:
- Reset (asserted at any time, including mid-frame):
  - forces state IDLE immediately;
  - grant=0, tx_axiiv=0, tx_axiid=0, tx_dest_mac=0, tx_etype=0, busy=0, underrun=0;
  - round-robin pointer=0, all counters=0.
- States: IDLE, GRANT, STREAM, PAD, WAIT_DONE, GAP. All outputs are registered.
- IDLE:
  - if any req is high, pick the first high bit at or after rr_ptr (wrapping modulo NUM_REQ);
  - latch that requester's dest_mac and etype into tx_dest_mac and tx_etype;
  - assert grant[i]; go to GRANT. This is one cycle of latency from req to grant.
- GRANT:
  - wait for req_axiiv[i]; forward it; go to STREAM;
  - rr_ptr <= i+1 (mod NUM_REQ).
- STREAM:
  - tx_axiiv/tx_axiid are req_axiiv[i]/req_axiid[i] registered (1-cycle latency), so tx_axiiv rises with no gap;
  - sym_cnt increments per forwarded symbol; saturates at MIN_PAYLOAD_BYTES*8/N.
  - On req_axiiv & req_last: drop grant. If sym_cnt+1 < minimum, go to PAD; else go to WAIT_DONE with tx_axiiv deasserted the following cycle.
  - If req_axiiv drops without last: set underrun, drop grant, treat the frame as ended (PAD or WAIT_DONE by the same rule).
- PAD:
  - tx_axiiv=1, tx_axiid=0 until sym_cnt reaches the minimum; then tx_axiiv=0 and go to WAIT_DONE;
  - symbol stream to ethernet_tx stays contiguous with no bubble between payload and pad.
- WAIT_DONE:
  - wait for a rising then a falling edge of tx_axiov_mon;
  - on the falling edge, load gap_cnt=IFG_CYCLES; go to GAP.
- GAP: decrement gap_cnt each cycle; at 0 go to IDLE. A req present in IDLE is granted on the next cycle.
- General rules:
  - req of non-granted requesters is ignored until IDLE;
  - a requester deasserting req before grant is not granted;
  - req_axiiv of non-granted requesters is ignored;
  - simultaneous requests are resolved only by rr_ptr, so NUM_REQ consecutive frames serve every active requester once.
- tx_dest_mac and tx_etype change only in IDLE.

Optional Feature:
- Macro: ETHER_TX_ARB_STATS_EN.
- Defined:
  - adds output frame_cnt (16*NUM_REQ);
  - slice i increments by 1, wrapping 0xFFFF->0, on each WAIT_DONE completion of a frame granted to i;
  - reset clears it.
- Undefined: port and counters absent; all other behaviour identical.

Test Plan:
- Single frame: req[0] with 200 symbols, last on the 200th -> grant[0] one cycle after req; 200 contiguous tx_axiiv cycles; tx_dest_mac and tx_etype match slice 0; no padding; busy returns to 0 IFG_CYCLES (48) cycles after tx_axiov_mon falls.
- Short frame: req[1] with 8 symbols (2 bytes) at N=2 -> 8 data symbols followed by 176 zero symbols; 184 total contiguous tx_axiiv cycles.
- Contention: req[0] and req[1] held high for 4 frames -> grant order 0,1,0,1; each new grant no earlier than IFG_CYCLES after the previous tx_axiov_mon fall.
- Underrun: req_axiiv[0] drops after 20 symbols without last -> underrun=1 (sticky); padding to 184; frame completes; next frame still served.
- Reset mid-STREAM: assert rst low at symbol 50 -> all outputs 0 in the same cycle without waiting for clk; after release, req[1] is granted first only if req[0] is low (rr_ptr=0).
- With ETHER_TX_ARB_STATS_EN: 3 frames on requester 0 and 1 on requester 1 -> frame_cnt = {16'd1, 16'd3}.
